vga_dither_out: RTL and testbench
=================================

# vga_dither_out

Parametrised video output stage between the core's 8-bit-per-channel RGB and the board's narrower VGA DAC (6-bit on SiDi, also usable on other boards). It tracks pixel/line position from the incoming sync and data-enable, applies 4x4 ordered (Bayer) dithering, optionally alternated per frame, before reducing IN_W to OUT_W bits. Sync and blanking are delayed to stay aligned with the colour path. It sits in the board top, directly in front of the VGA pins.

## Interface
- IN_W, 8, input bits per channel
- OUT_W, 6, output bits per channel; 1 ≤ OUT_W ≤ IN_W, otherwise elaboration error
- VS_POL, 1'b0, active level of vs_in; the leading edge is the transition to this level
- TEMPORAL, 0, 1 = Bayer index rotated per frame
- clk  in  1  pixel-domain clock
- reset  in  1  asynchronous, active-high
- ce_pix  in  1  pixel clock enable; all state advances only when high
- r_in, g_in, b_in  in  IN_W  colour input
- hs_in, vs_in  in  1  sync input, passed through with the pipeline delay
- de_in  in  1  active video
- r_out, g_out, b_out  out  OUT_W  dithered colour, 0 during blanking
- hs_out, vs_out, de_out  out  1  delayed sync/enable

## Operation
- D = IN_W − OUT_W, the number of dropped bits. D = 0 gives a pure registered pass-through.
- x[1:0]: cleared on the falling edge of de_in; increments on each ce_pix with de_in = 1. It wraps modulo 4.
- y[1:0]: increments on each de_in falling edge; cleared on the vs_in leading edge.
- frame[1:0]: increments on each vs_in leading edge. Edge detection uses registered previous values, updated on ce_pix.
- Index: ix = x ^ (TEMPORAL ? frame[0]x2 : 0) and iy = y ^ (TEMPORAL ? frame[1]x2 : 0).
- Bayer values by row iy, columns ix 0..3:
  - row 0: 0 8 2 10
  - row 1: 12 4 14 6
  - row 2: 3 11 1 9
  - row 3: 15 7 13 5
- Threshold t:
  - D ≤ 4: bayer >> (4 − D)
  - D > 4: bayer << (D − 4)
  - t is D bits wide.
- Per channel: s = in + t computed at IN_W+1 bits. If s overflows, saturate to all-ones (IN_W bits). Output = s[IN_W−1:D].
- Stage 1 registers the inputs, t and de/hs/vs. Stage 2 registers the add/saturate/truncate result and the delayed syncs.
- When stage-2 de is 0, the colour outputs are forced to 0.

## Timing
- Latency: exactly 2 ce_pix-qualified cycles from input to output for colour, hs, vs and de. All outputs change only on clk edges where ce_pix = 1.
- ce_pix low: every register holds, including the counters.
- Reset, asserted at any time (including mid-line): all outputs, pipeline registers, x, y, frame and edge-detect registers go to 0 immediately. The first ce_pix after release restarts counting at x = y = 0.
- de_in falling and vs_in leading edge on the same ce_pix: y goes to 0 (clear wins). x is cleared.
- de_in held high for more than 4 pixels: x wraps 3 → 0 with no other effect.
- The input value at maximum with a non-zero threshold never wraps to 0 (saturation).

## Configuration
- VGA_DITHER_EN defined: dithering as described.
- VGA_DITHER_EN undefined:
  - t is forced to 0, giving plain truncation in[IN_W−1:D].
  - The counters and frame logic are removed.
  - The 2-cycle latency and the blanking behaviour are unchanged.

## Test plan
- IN_W = 8, OUT_W = 6, macro defined, y = 0, constant 0x82 on all channels over 4 pixels → output 0x20, 0x21, 0x20, 0x21 (t = 0, 2, 0, 2).
- Same configuration, input 0xFE at x = 1, y = 0 → output 0x3F (saturation, no wrap to 0x00).
- Macro undefined, input 0x82 across 2 lines → every output 0x20; hs_out/vs_out/de_out equal the inputs delayed by 2 ce_pix cycles.
- OUT_W = IN_W = 8, random data with ce_pix toggling 1-of-3 → output equals input delayed by 2 enabled cycles; values held while ce_pix = 0.
- TEMPORAL = 1, input 0x82 at x = 0, y = 0:
  - frame 0 → output 0x20
  - after one vs_in leading edge (frame 1, ix = 2, t = 0) → 0x20
  - after a second edge (frame 2, iy = 2, t = 0) → 0x20
  - the same check at x = 1 gives 0x21, 0x21, 0x21 (t = 2, 2, 2)
- Assert reset mid-line with de_in = 1 → all outputs 0 at once. After release, the first active pixel uses x = 0, y = 0 (t = 0).

Source files
------------

// File: rtl/vga_dither_out.sv
// vga_dither_out: reduces IN_W-bit RGB to OUT_W bits with 4x4 Bayer ordered dither (built only with VGA_DITHER_EN).
// Latency 2 ce_pix-qualified cycles for colour and syncs; no backpressure, every register advances only on ce_pix.
module vga_dither_out #(
  parameter int   IN_W     = 8,
  parameter int   OUT_W    = 6,
  parameter logic VS_POL   = 1'b0,
  parameter int   TEMPORAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             de_out
);

  localparam int D = IN_W - OUT_W;

  if (OUT_W < 1 || OUT_W > IN_W) begin : g_bad_width
    $error("vga_dither_out: OUT_W must lie in 1..IN_W");
  end

  function automatic logic [3:0] f_bayer(input logic [1:0] iy, input logic [1:0] ix);
    logic [3:0] v;
    case ({iy, ix})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
      4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  // Add the threshold one bit wider so a carry saturates instead of wrapping to black.
  function automatic logic [OUT_W-1:0] f_dither(input logic [IN_W-1:0] v, input logic [IN_W-1:0] t);
    logic [IN_W:0] s;
    s = {1'b0, v} + {1'b0, t};
    if (s[IN_W]) return '1;
    return OUT_W'(s >> D);
  endfunction

  logic [IN_W-1:0] w_t;

`ifdef VGA_DITHER_EN
  logic [1:0]      r_x, r_y, r_frame;
  logic            r_de_prev, r_vs_prev;
  logic            w_de_fall, w_vs_lead;
  logic [1:0]      w_ix, w_iy;
  logic [IN_W+3:0] w_tmp;

  assign w_de_fall = r_de_prev & ~de_in;
  assign w_vs_lead = (vs_in == VS_POL) && (r_vs_prev != VS_POL);
  assign w_ix      = r_x ^ ((TEMPORAL != 0) ? {r_frame[0], 1'b0} : 2'b00);
  assign w_iy      = r_y ^ ((TEMPORAL != 0) ? {r_frame[1], 1'b0} : 2'b00);
  assign w_tmp     = {{IN_W{1'b0}}, f_bayer(w_iy, w_ix)};

  if (D <= 4) begin : g_shr
    assign w_t = IN_W'(w_tmp >> (4 - D));
  end else begin : g_shl
    assign w_t = IN_W'(w_tmp << (D - 4));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_frame   <= '0;
      r_de_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else if (ce_pix) begin
      r_de_prev <= de_in;
      r_vs_prev <= vs_in;
      if (w_de_fall)  r_x <= '0;
      else if (de_in) r_x <= r_x + 2'd1;
      // A frame start on the same pixel as a line end restarts the row count.
      if (w_vs_lead)      r_y <= '0;
      else if (w_de_fall) r_y <= r_y + 2'd1;
      if (w_vs_lead)      r_frame <= r_frame + 2'd1;
    end
  end
`else
  logic w_unused_cfg;

  assign w_t          = '0;
  assign w_unused_cfg = VS_POL ^ (TEMPORAL != 0);
`endif

  logic [IN_W-1:0]  r_r1, r_g1, r_b1, r_t1;
  logic             r_hs1, r_vs1, r_de1;
  logic [OUT_W-1:0] r_r2, r_g2, r_b2;
  logic             r_hs2, r_vs2, r_de2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r1  <= '0;
      r_g1  <= '0;
      r_b1  <= '0;
      r_t1  <= '0;
      r_hs1 <= 1'b0;
      r_vs1 <= 1'b0;
      r_de1 <= 1'b0;
      r_r2  <= '0;
      r_g2  <= '0;
      r_b2  <= '0;
      r_hs2 <= 1'b0;
      r_vs2 <= 1'b0;
      r_de2 <= 1'b0;
    end else if (ce_pix) begin
      r_r1  <= r_in;
      r_g1  <= g_in;
      r_b1  <= b_in;
      r_t1  <= w_t;
      r_hs1 <= hs_in;
      r_vs1 <= vs_in;
      r_de1 <= de_in;
      // Blanking is folded into stage 2 so the colour outputs stay purely registered.
      r_r2  <= r_de1 ? f_dither(r_r1, r_t1) : '0;
      r_g2  <= r_de1 ? f_dither(r_g1, r_t1) : '0;
      r_b2  <= r_de1 ? f_dither(r_b1, r_t1) : '0;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      r_de2 <= r_de1;
    end
  end

  assign r_out  = r_r2;
  assign g_out  = r_g2;
  assign b_out  = r_b2;
  assign hs_out = r_hs2;
  assign vs_out = r_vs2;
  assign de_out = r_de2;

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench: 8->6 dither (A), 8->8 pass-through with sparse ce_pix (P), 8->6 temporal (T).
module tb_vga_dither_out;

`ifdef VGA_DITHER_EN
  localparam bit DITH = 1'b1;
`else
  localparam bit DITH = 1'b0;
`endif

  typedef logic [26:0] vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce_a, ce_p, ce_t;
  logic [7:0] r_i, g_i, b_i;
  logic       hs_i, vs_i, de_i;

  logic [5:0] r_oa, g_oa, b_oa, r_ot, g_ot, b_ot;
  logic [7:0] r_op, g_op, b_op;
  logic       hs_oa, vs_oa, de_oa, hs_op, vs_op, de_op, hs_ot, vs_ot, de_ot;

  vec_t qa[$], qp[$], qt[$];
  vec_t last_p;
  int   na, np, nt;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_dither_out #(.IN_W(8), .OUT_W(6), .VS_POL(1'b0), .TEMPORAL(0)) u_a (
    .clk(clk), .reset(reset), .ce_pix(ce_a),
    .r_in(r_i), .g_in(g_i), .b_in(b_i), .hs_in(hs_i), .vs_in(vs_i), .de_in(de_i),
    .r_out(r_oa), .g_out(g_oa), .b_out(b_oa), .hs_out(hs_oa), .vs_out(vs_oa), .de_out(de_oa));

  vga_dither_out #(.IN_W(8), .OUT_W(8), .VS_POL(1'b0), .TEMPORAL(0)) u_p (
    .clk(clk), .reset(reset), .ce_pix(ce_p),
    .r_in(r_i), .g_in(g_i), .b_in(b_i), .hs_in(hs_i), .vs_in(vs_i), .de_in(de_i),
    .r_out(r_op), .g_out(g_op), .b_out(b_op), .hs_out(hs_op), .vs_out(vs_op), .de_out(de_op));

  vga_dither_out #(.IN_W(8), .OUT_W(6), .VS_POL(1'b0), .TEMPORAL(1)) u_t (
    .clk(clk), .reset(reset), .ce_pix(ce_t),
    .r_in(r_i), .g_in(g_i), .b_in(b_i), .hs_in(hs_i), .vs_in(vs_i), .de_in(de_i),
    .r_out(r_ot), .g_out(g_ot), .b_out(b_ot), .hs_out(hs_ot), .vs_out(vs_ot), .de_out(de_ot));

  function automatic vec_t pk6(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                               input logic hs, input logic vs, input logic de);
    return {2'b00, r, 2'b00, g, 2'b00, b, hs, vs, de};
  endfunction

  task automatic chk(input string nm, input vec_t act, input vec_t want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s (check %0d): got %h, expected %h", nm, n_chk, act, want);
    end
  endtask

  // Monitor: output for the input sampled on enabled edge k is visible after enabled edge k+1.
  always @(posedge clk or posedge reset) begin : mon
    logic ca, cp, ct;
    vec_t e;
    ca = ce_a;
    cp = ce_p;
    ct = ce_t;
    #1;
    if (reset) begin
      chk("rst_a", pk6(r_oa, g_oa, b_oa, hs_oa, vs_oa, de_oa), '0);
      chk("rst_p", {r_op, g_op, b_op, hs_op, vs_op, de_op}, '0);
      chk("rst_t", pk6(r_ot, g_ot, b_ot, hs_ot, vs_ot, de_ot), '0);
      qa.delete(); qp.delete(); qt.delete();
      na = 0; np = 0; nt = 0;
    end else begin
      if (ca) begin
        na++;
        if (na >= 2) begin
          if (qa.size() == 0) chk("a_underflow", 27'd1, 27'd0);
          else begin
            e = qa.pop_front();
            chk("a_out", pk6(r_oa, g_oa, b_oa, hs_oa, vs_oa, de_oa), e);
          end
        end
      end
      if (cp) begin
        np++;
        if (np >= 2) begin
          if (qp.size() == 0) chk("p_underflow", 27'd1, 27'd0);
          else begin
            last_p = qp.pop_front();
            chk("p_out", {r_op, g_op, b_op, hs_op, vs_op, de_op}, last_p);
          end
        end
      end else if (np >= 2) begin
        chk("p_hold", {r_op, g_op, b_op, hs_op, vs_op, de_op}, last_p);
      end
      if (ct) begin
        nt++;
        if (nt >= 2) begin
          if (qt.size() == 0) chk("t_underflow", 27'd1, 27'd0);
          else begin
            e = qt.pop_front();
            chk("t_out", pk6(r_ot, g_ot, b_ot, hs_ot, vs_ot, de_ot), e);
          end
        end
      end
    end
  end

  // sel: 0 = A, 1 = P, 2 = T, 3 = no enable (nothing pushed).
  task automatic drv(input int sel, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic hs, input logic vs, input logic de,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    @(negedge clk);
    r_i = r; g_i = g; b_i = b; hs_i = hs; vs_i = vs; de_i = de;
    ce_a = (sel == 0);
    ce_p = (sel == 1);
    ce_t = (sel == 2);
    case (sel)
      0: qa.push_back({er, eg, eb, hs, vs, de});
      1: qp.push_back({er, eg, eb, hs, vs, de});
      2: qt.push_back({er, eg, eb, hs, vs, de});
      default: ;
    endcase
  endtask

  task automatic px(input int sel, input logic [7:0] v, input logic [7:0] ed, input logic [7:0] et);
    logic [7:0] e;
    e = DITH ? ed : et;
    drv(sel, v, v, v, 1'b0, 1'b1, 1'b1, e, e, e);
  endtask

  task automatic bl(input int sel, input logic hs, input logic vs);
    drv(sel, 8'hAA, 8'h55, 8'hAA, hs, vs, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic row4(input int sel, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    px(sel, 8'h82, e0, 8'h20);
    px(sel, 8'h82, e1, 8'h20);
    px(sel, 8'h82, e2, 8'h20);
    px(sel, 8'h82, e3, 8'h20);
  endtask

  initial begin
    logic [7:0] r, g, b;
    logic       hs, vs, de;
    reset = 1'b0;
    ce_a = 1'b0; ce_p = 1'b0; ce_t = 1'b0;
    r_i = '0; g_i = '0; b_i = '0; hs_i = 1'b0; vs_i = 1'b1; de_i = 1'b0;
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // P: pass-through, ce_pix high one cycle in three, garbage on the idle cycles
    for (int i = 0; i < 14; i++) begin
      drv(3, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'h0, 8'h0, 8'h0);
      drv(3, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'h0, 8'h0, 8'h0);
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      hs = 1'($urandom); vs = 1'($urandom); de = (i % 4) != 3;
      drv(1, r, g, b, hs, vs, de, de ? r : 8'h00, de ? g : 8'h00, de ? b : 8'h00);
    end

    // T: x = 0,1 over frames 0, 1, 2
    bl(2, 1'b0, 1'b1); bl(2, 1'b0, 1'b1);
    px(2, 8'h82, 8'h20, 8'h20); px(2, 8'h82, 8'h21, 8'h20);
    bl(2, 1'b1, 1'b1); bl(2, 1'b0, 1'b0); bl(2, 1'b0, 1'b1); bl(2, 1'b0, 1'b1);
    px(2, 8'h82, 8'h20, 8'h20); px(2, 8'h82, 8'h21, 8'h20);
    bl(2, 1'b1, 1'b1); bl(2, 1'b0, 1'b0); bl(2, 1'b0, 1'b1);
    px(2, 8'h82, 8'h20, 8'h20); px(2, 8'h82, 8'h21, 8'h20);
    bl(2, 1'b0, 1'b1); bl(2, 1'b0, 1'b1);

    // A: line 0 with x wrap, saturation and distinct channels
    bl(0, 1'b0, 1'b1); bl(0, 1'b0, 1'b1);
    row4(0, 8'h20, 8'h21, 8'h20, 8'h21);
    px(0, 8'h82, 8'h20, 8'h20);
    px(0, 8'hFE, 8'h3F, 8'h3F);
    drv(0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1, 1'b1, 8'h04, 8'h08, 8'h0C);
    drv(0, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, DITH ? 8'h01 : 8'h00, 8'h3F);
    // de falls on the same pixel as the vsync leading edge: y must restart at 0
    bl(0, 1'b1, 1'b0); bl(0, 1'b1, 1'b0); bl(0, 1'b0, 1'b1);
    row4(0, 8'h20, 8'h21, 8'h20, 8'h21);
    bl(0, 1'b1, 1'b1); bl(0, 1'b0, 1'b1);
    row4(0, 8'h21, 8'h20, 8'h21, 8'h20);
    bl(0, 1'b1, 1'b1); bl(0, 1'b0, 1'b1);
    px(0, 8'h82, 8'h20, 8'h20); px(0, 8'h82, 8'h21, 8'h20); px(0, 8'h82, 8'h20, 8'h20);

    // mid-line asynchronous reset with de_in still high
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ce_a = 1'b0;
    px(0, 8'h82, 8'h20, 8'h20); px(0, 8'h82, 8'h21, 8'h20);
    bl(0, 1'b0, 1'b1); bl(0, 1'b0, 1'b1); bl(0, 1'b0, 1'b1);

    repeat (3) drv(3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
